sram_port_arbiter: RTL and testbench
====================================

Name: sram_port_arbiter

Overview:
- Shares the single read/write port of the 32x256 data SRAM macro between two requesters: the Ibex core data interface and a fabric-side master driven from eFPGA user I/O.
- Supplies proper grant/rvalid handshakes, replacing the current constant-1 rvalid tie-off.
- Selects between round-robin and core-priority arbitration; core-priority mode has an anti-starvation limit.
- Flags accesses outside the SRAM window as errors instead of aliasing them.

Parameters:
- ADDR_W, 8, SRAM word-address width (256 words).
- BASE_ADDR, 32'h0000_0000, byte base address of the SRAM window; aligned to 4*2^ADDR_W.
- PRIO_MODE, 0, 0 = round-robin, 1 = core fixed priority.
- MAX_WAIT, 4, in PRIO_MODE=1 only: consecutive cycles a requesting fabric may be denied before it is forced a grant; range 1..15.

Ports:
- clk  in  1  system clock, rising edge
- resetn  in  1  asynchronous active-low reset
- core_req_i  in  1  core request; held until granted
- core_gnt_o  out  1  core grant, combinational, same cycle
- core_rvalid_o  out  1  core response valid, one cycle after grant
- core_we_i  in  1  core write enable
- core_be_i  in  4  core byte enables
- core_addr_i  in  32  core byte address
- core_wdata_i  in  32  core write data
- core_rdata_o  out  32  core read data, valid with core_rvalid_o
- core_err_o  out  1  core out-of-window error, valid with core_rvalid_o
- fab_req_i, fab_gnt_o, fab_rvalid_o, fab_we_i, fab_be_i[3:0], fab_addr_i[31:0], fab_wdata_i[31:0], fab_rdata_o[31:0], fab_err_o  same as core_*, fabric side
- sram_csb_o  out  1  SRAM chip select, active low
- sram_web_o  out  1  SRAM write enable, active low
- sram_wmask_o  out  4  SRAM byte write mask
- sram_addr_o  out  ADDR_W  SRAM word address
- sram_din_o  out  32  SRAM write data
- sram_dout_i  in  32  SRAM read data

Behaviour:
- At most one grant per cycle. gnt_o is combinational from req_i and the arbiter state.
- In-window test: addr[31:ADDR_W+2] == BASE_ADDR[31:ADDR_W+2]. Word address is addr[ADDR_W+1:2]; addr[1:0] is ignored.
- Granted in-window access: sram_csb_o=0, sram_web_o=~we, sram_wmask_o=be, sram_addr_o, sram_din_o driven from the winner in the same cycle.
- No grant, or granted out-of-window access: sram_csb_o=1, sram_web_o=1, wmask=0. Addr/din hold the winner's value, else 0.
- Response register: rsp_owner (none/core/fab) and rsp_err, loaded on each grant edge, cleared when there is no grant.
- rvalid_o is asserted for exactly one cycle, the cycle after the grant, for both reads and writes.
- rdata_o = sram_dout_i when the access was an in-window read, else 32'h0. err_o = rsp_err during rvalid, else 0.
- Back-to-back: a new grant may coincide with the previous rvalid. Throughput is 1 access/cycle.
- Round-robin (PRIO_MODE=0): a 1-bit last_winner register.
  - Both requesting: grant the one that is not last_winner.
  - One requesting: grant it.
  - last_winner updates on every grant.
- Core priority (PRIO_MODE=1): wait_cnt (4 bits) counts cycles with fab_req_i=1 and fab_gnt_o=0.
  - Both requesting: the core wins unless wait_cnt >= MAX_WAIT, in which case the fabric wins.
  - wait_cnt clears on a fabric grant or when fab_req_i=0. It saturates at 15.
- Out-of-window accesses consume an arbitration slot like normal accesses.
- Reset (resetn=0, asynchronous):
  - rsp_owner=none, rsp_err=0, last_winner=fab (core wins the first tie), wait_cnt=0.
  - While reset is asserted: all gnt=0, rvalid=0, err=0, rdata=0, sram_csb_o=1, sram_web_o=1, wmask=0, addr=0, din=0.
- Reset mid-transaction: a pending rvalid is dropped. Requesters re-issue after reset.
- Requester protocol violations (dropping req before gnt) are tolerated; nothing is granted in that cycle.

Test Plan:
- Reset asserted mid-read with rvalid due next cycle -> no rvalid; csb=1, gnt=0 throughout reset; first post-reset tie grants core.
- Core write addr 0x10, be=4'b0011, wdata 0xDEADBEEF, then read 0x10 -> write rvalid at T+1 (err=0, rdata=0); read rvalid at T+3; csb=0/web=0/wmask=0011/addr=4 on the write cycle.
- RR mode, both requesting continuously for 6 cycles -> grants alternate core,fab,core,fab,core,fab; each rvalid routed to the matching side one cycle later.
- PRIO_MODE=1, MAX_WAIT=4, both requesting continuously -> core granted 4 cycles, fabric on the 5th, wait_cnt back to 0, repeating pattern.
- Fabric read at addr 0x0000_0400 (out of window, BASE=0) -> fab_gnt same cycle; csb stays 1; fab_rvalid next cycle with fab_err=1, fab_rdata=0.
- Core read at 0x20 followed immediately by fabric read at 0x24 -> rvalids on consecutive cycles, each carrying the sram_dout_i of its own access, no cross-routing.

Source files
------------

// File: rtl/sram_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// sram_port_arbiter_if
//   One requester port of the shared data-SRAM arbiter (OBI-like handshake).
//   master : the requester (Ibex data interface or fabric master)
//   slave  : the arbiter
//   req    master->slave  request, held until gnt
//   gnt    slave->master  grant, combinational, same cycle as req
//   rvalid slave->master  response valid, the cycle after gnt
//   we/be/addr/wdata      master->slave  access attributes (byte address)
//   rdata/err             slave->master  response payload, valid with rvalid
// ---------------------------------------------------------------------------
interface sram_port_arbiter_if;
  logic        req;
  logic        gnt;
  logic        rvalid;
  logic        we;
  logic [3:0]  be;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        err;

  modport master (
    output req, we, be, addr, wdata,
    input  gnt, rvalid, rdata, err
  );

  modport slave (
    input  req, we, be, addr, wdata,
    output gnt, rvalid, rdata, err
  );
endinterface

// File: rtl/sram_port_arbiter.sv
// ---------------------------------------------------------------------------
// sram_port_arbiter
//   Shares the single read/write port of the data SRAM macro between the core
//   data interface and a fabric-side master. One access per cycle; the grant
//   is combinational and the response (rvalid/rdata/err) follows one cycle
//   later. Accesses outside the SRAM window are granted but do not touch the
//   macro; they answer with err=1 instead of aliasing.
//
//   Ports
//     clk, resetn          clock (rising edge), async active-low reset
//     core, fab            requester ports (slave side of the interface)
//     sram_csb_o           SRAM chip select, active low
//     sram_web_o           SRAM write enable, active low
//     sram_wmask_o         SRAM byte write mask
//     sram_addr_o          SRAM word address
//     sram_din_o           SRAM write data
//     sram_dout_i          SRAM read data (valid the cycle after a read)
//
//   Parameters
//     ADDR_W     SRAM word-address width
//     BASE_ADDR  byte base of the window, aligned to 4*2^ADDR_W
//     PRIO_MODE  0 = round-robin, 1 = core priority with anti-starvation
//     MAX_WAIT   (PRIO_MODE=1) denied fabric cycles before a forced grant, 1..15
// ---------------------------------------------------------------------------
module sram_port_arbiter #(
  parameter int unsigned ADDR_W    = 8,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned PRIO_MODE = 0,
  parameter int unsigned MAX_WAIT  = 4
) (
  input  logic                  clk,
  input  logic                  resetn,
  sram_port_arbiter_if.slave    core,
  sram_port_arbiter_if.slave    fab,
  output logic                  sram_csb_o,
  output logic                  sram_web_o,
  output logic [3:0]            sram_wmask_o,
  output logic [ADDR_W-1:0]     sram_addr_o,
  output logic [31:0]           sram_din_o,
  input  logic [31:0]           sram_dout_i
);

  localparam int unsigned TAG_LSB = ADDR_W + 2;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CORE = 2'd1,
    OWN_FAB  = 2'd2
  } owner_e;

  typedef enum logic {
    WIN_CORE = 1'b0,
    WIN_FAB  = 1'b1
  } winner_e;

  // Response pipeline and arbiter state
  owner_e      rsp_owner_q, rsp_owner_d;
  logic        rsp_err_q,   rsp_err_d;
  logic        rsp_rd_q,    rsp_rd_d;
  winner_e     last_winner_q, last_winner_d;
  logic [3:0]  wait_cnt_q,  wait_cnt_d;

  // Arbitration and winner mux
  logic        pick_core;
  logic        gnt_core;
  logic        gnt_fab;
  logic        any_gnt;
  logic        win_we;
  logic [3:0]  win_be;
  logic [31:0] win_addr;
  logic [31:0] win_wdata;
  logic        in_win;
  logic        access;
  logic        addr_lsb_unused;

  // -------------------------------------------------------------------------
  // Arbitration
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned; a missing default on any branch infers a latch.
    pick_core = 1'b0;
    if (PRIO_MODE == 0) begin
      // Round-robin: on a tie, the side that did not win last time goes.
      pick_core = (last_winner_q == WIN_FAB);
    end else begin
      // Core priority, unless the fabric has been denied MAX_WAIT cycles.
      pick_core = (wait_cnt_q < 4'(MAX_WAIT));
    end

    // Reset gates the grants combinationally so nothing reaches the macro
    // while resetn is low, even with requests asserted.
    gnt_core = resetn & core.req & (~fab.req | pick_core);
    gnt_fab  = resetn & fab.req & ~gnt_core;
    any_gnt  = gnt_core | gnt_fab;

    win_we    = gnt_fab ? fab.we    : core.we;
    win_be    = gnt_fab ? fab.be    : core.be;
    win_addr  = gnt_fab ? fab.addr  : core.addr;
    win_wdata = gnt_fab ? fab.wdata : core.wdata;

    in_win = (win_addr[31:TAG_LSB] == BASE_ADDR[31:TAG_LSB]);
    access = any_gnt & in_win;
  end

  // Byte offset within the word plays no part in a word-wide macro access.
  assign addr_lsb_unused = ^win_addr[1:0];

  assign core.gnt = gnt_core;
  assign fab.gnt  = gnt_fab;

  // -------------------------------------------------------------------------
  // SRAM drive: out-of-window grants keep the macro deselected but still
  // present the winner's address/data on the bus.
  // -------------------------------------------------------------------------
  assign sram_csb_o   = ~access;
  assign sram_web_o   = ~(access & win_we);
  assign sram_wmask_o = access  ? win_be                     : 4'h0;
  assign sram_addr_o  = any_gnt ? win_addr[TAG_LSB-1:2]      : '0;
  assign sram_din_o   = any_gnt ? win_wdata                  : 32'h0;

  // -------------------------------------------------------------------------
  // Next-state
  // -------------------------------------------------------------------------
  always_comb begin
    rsp_owner_d   = OWN_NONE;
    rsp_err_d     = any_gnt & ~in_win;
    rsp_rd_d      = access & ~win_we;
    last_winner_d = last_winner_q;
    wait_cnt_d    = wait_cnt_q;

    if (gnt_core) begin
      rsp_owner_d = OWN_CORE;
    end else if (gnt_fab) begin
      rsp_owner_d = OWN_FAB;
    end

    if (any_gnt) begin
      last_winner_d = gnt_fab ? WIN_FAB : WIN_CORE;
    end

    // Counts consecutive denied fabric cycles; saturates at 15.
    if (!fab.req || gnt_fab) begin
      wait_cnt_d = 4'h0;
    end else if (wait_cnt_q != 4'hF) begin
      wait_cnt_d = wait_cnt_q + 4'h1;
    end
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop regardless of order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rsp_owner_q   <= OWN_NONE;
      rsp_err_q     <= 1'b0;
      rsp_rd_q      <= 1'b0;
      last_winner_q <= WIN_FAB;   // core takes the first tie after reset
      wait_cnt_q    <= 4'h0;
    end else begin
      rsp_owner_q   <= rsp_owner_d;
      rsp_err_q     <= rsp_err_d;
      rsp_rd_q      <= rsp_rd_d;
      last_winner_q <= last_winner_d;
      wait_cnt_q    <= wait_cnt_d;
    end
  end

  // -------------------------------------------------------------------------
  // Responses: rdata carries the macro output only for an in-window read.
  // -------------------------------------------------------------------------
  assign core.rvalid = (rsp_owner_q == OWN_CORE);
  assign core.err    = core.rvalid & rsp_err_q;
  assign core.rdata  = (core.rvalid && rsp_rd_q) ? sram_dout_i : 32'h0;

  assign fab.rvalid  = (rsp_owner_q == OWN_FAB);
  assign fab.err     = fab.rvalid & rsp_err_q;
  assign fab.rdata   = (fab.rvalid && rsp_rd_q) ? sram_dout_i : 32'h0;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sram_port_arbiter
//   Drives the same requester stimulus into two arbiter instances: index 0 in
//   round-robin mode, index 1 in core-priority mode (MAX_WAIT=4). Each has its
//   own behavioural SRAM. Vectors carry the expected grant for each mode; the
//   expected response of every grant is queued and compared when due.
// ---------------------------------------------------------------------------
module tb_sram_port_arbiter;

  logic        clk;
  logic        resetn;

  logic        creq, cwe, freq, fwe;
  logic [3:0]  cbe, fbe;
  logic [31:0] caddr, cwdata, faddr, fwdata;

  // Observed per instance: {fab_gnt, core_gnt}; {csb, web, wmask, addr, din};
  // {core rvalid, err, rdata, fab rvalid, err, rdata}
  logic [1:0]  gnt_v  [2];
  logic [45:0] pins_v [2];
  logic [67:0] rsp_v  [2];

  typedef struct packed {
    logic        creq;
    logic        cwe;
    logic [3:0]  cbe;
    logic [31:0] caddr;
    logic [31:0] cwdata;
    logic        freq;
    logic        fwe;
    logic [3:0]  fbe;
    logic [31:0] faddr;
    logic [31:0] fwdata;
    logic [1:0]  exp_rr;   // {fab, core}
    logic [1:0]  exp_pr;
  } vec_t;

  typedef struct packed {
    logic        dut;
    logic        side;     // 0 core, 1 fabric
    logic        err;
    logic [31:0] rdata;
    logic [31:0] cyc;
  } rsp_exp_t;

  rsp_exp_t    sb_q [$];
  vec_t        vecs [$];
  logic [31:0] ref_mem [2][256];
  int          n_vec = 0;
  int          n_bad = 0;
  logic [31:0] cyc   = 0;

  function automatic logic [31:0] init_word(input int i);
    return 32'hC0DE_0000 | 32'(i);
  endfunction

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    sram_port_arbiter_if core_if ();
    sram_port_arbiter_if fab_if ();

    logic        sram_csb, sram_web;
    logic [3:0]  sram_wmask;
    logic [7:0]  sram_addr;
    logic [31:0] sram_din;
    logic [31:0] sram_dout;
    logic [31:0] mem [256];

    assign core_if.req   = creq;
    assign core_if.we    = cwe;
    assign core_if.be    = cbe;
    assign core_if.addr  = caddr;
    assign core_if.wdata = cwdata;
    assign fab_if.req    = freq;
    assign fab_if.we     = fwe;
    assign fab_if.be     = fbe;
    assign fab_if.addr   = faddr;
    assign fab_if.wdata  = fwdata;

    assign gnt_v[g]  = {fab_if.gnt, core_if.gnt};
    assign pins_v[g] = {sram_csb, sram_web, sram_wmask, sram_addr, sram_din};
    assign rsp_v[g]  = {core_if.rvalid, core_if.err, core_if.rdata,
                        fab_if.rvalid,  fab_if.err,  fab_if.rdata};

    sram_port_arbiter #(
      .ADDR_W    (8),
      .BASE_ADDR (32'h0000_0000),
      .PRIO_MODE (g),
      .MAX_WAIT  (4)
    ) u_dut (
      .clk          (clk),
      .resetn       (resetn),
      .core         (core_if),
      .fab          (fab_if),
      .sram_csb_o   (sram_csb),
      .sram_web_o   (sram_web),
      .sram_wmask_o (sram_wmask),
      .sram_addr_o  (sram_addr),
      .sram_din_o   (sram_din),
      .sram_dout_i  (sram_dout)
    );

    // NOTE: the SRAM array has no reset; contents survive resetn like a macro.
    initial begin
      sram_dout = 32'h0;
      for (int i = 0; i < 256; i++) mem[i] = init_word(i);
    end

    always @(posedge clk) begin
      if (!sram_csb) begin
        if (!sram_web) begin
          for (int b = 0; b < 4; b++)
            if (sram_wmask[b]) mem[sram_addr][8*b +: 8] <= sram_din[8*b +: 8];
        end else begin
          sram_dout <= mem[sram_addr];
        end
      end
    end
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(
    input logic creq_i, input logic cwe_i, input logic [3:0] cbe_i,
    input logic [31:0] caddr_i, input logic [31:0] cwdata_i,
    input logic freq_i, input logic fwe_i, input logic [3:0] fbe_i,
    input logic [31:0] faddr_i, input logic [31:0] fwdata_i,
    input logic [1:0] exp_rr_i, input logic [1:0] exp_pr_i);
    vec_t v;
    v.creq = creq_i; v.cwe = cwe_i; v.cbe = cbe_i; v.caddr = caddr_i; v.cwdata = cwdata_i;
    v.freq = freq_i; v.fwe = fwe_i; v.fbe = fbe_i; v.faddr = faddr_i; v.fwdata = fwdata_i;
    v.exp_rr = exp_rr_i; v.exp_pr = exp_pr_i;
    return v;
  endfunction

  task automatic drive_idle();
    creq = 1'b0; cwe = 1'b0; cbe = 4'h0; caddr = 32'h0; cwdata = 32'h0;
    freq = 1'b0; fwe = 1'b0; fbe = 4'h0; faddr = 32'h0; fwdata = 32'h0;
  endtask

  task automatic check_idle(input string tag);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("%s dut%0d gnt", tag, d), 128'(gnt_v[d]), 128'(2'b00));
      check($sformatf("%s dut%0d sram", tag, d), 128'(pins_v[d]), 128'({1'b1, 1'b1, 4'h0, 8'h0, 32'h0}));
      check($sformatf("%s dut%0d rsp", tag, d), 128'(rsp_v[d]), 128'(68'h0));
    end
  endtask

  // One cycle: drive at the falling edge, compare 1ns later, then queue the
  // response each expected grant owes and update the reference memory.
  task automatic step(input vec_t v);
    logic [1:0]  exp_g;
    logic [45:0] exp_p;
    logic [67:0] exp_r [2];
    logic [31:0] a, wd;
    logic        we, inw;
    logic [3:0]  be;
    logic [7:0]  w;
    rsp_exp_t    e;

    @(negedge clk);
    creq = v.creq; cwe = v.cwe; cbe = v.cbe; caddr = v.caddr; cwdata = v.cwdata;
    freq = v.freq; fwe = v.fwe; fbe = v.fbe; faddr = v.faddr; fwdata = v.fwdata;
    #1;
    cyc++;

    exp_r[0] = 68'h0;
    exp_r[1] = 68'h0;
    while (sb_q.size() > 0 && sb_q[0].cyc == cyc) begin
      e = sb_q.pop_front();
      if (!e.side) exp_r[e.dut][67:34] = {1'b1, e.err, e.rdata};
      else         exp_r[e.dut][33:0]  = {1'b1, e.err, e.rdata};
    end

    for (int d = 0; d < 2; d++) begin
      check($sformatf("cyc%0d dut%0d rsp", cyc, d), 128'(rsp_v[d]), 128'(exp_r[d]));

      exp_g = (d == 0) ? v.exp_rr : v.exp_pr;
      check($sformatf("cyc%0d dut%0d gnt", cyc, d), 128'(gnt_v[d]), 128'(exp_g));

      if (exp_g == 2'b00) begin
        exp_p = {1'b1, 1'b1, 4'h0, 8'h0, 32'h0};
      end else begin
        a   = exp_g[1] ? v.faddr  : v.caddr;
        wd  = exp_g[1] ? v.fwdata : v.cwdata;
        we  = exp_g[1] ? v.fwe    : v.cwe;
        be  = exp_g[1] ? v.fbe    : v.cbe;
        inw = (a[31:10] == 22'h0);
        w   = a[9:2];
        exp_p = {~inw, inw ? ~we : 1'b1, inw ? be : 4'h0, w, wd};
        e.dut   = 1'(d);
        e.side  = exp_g[1];
        e.err   = ~inw;
        e.rdata = (inw && !we) ? ref_mem[d][w] : 32'h0;
        e.cyc   = cyc + 1;
        sb_q.push_back(e);
        if (inw && we)
          for (int b = 0; b < 4; b++)
            if (be[b]) ref_mem[d][w][8*b +: 8] = wd[8*b +: 8];
      end
      check($sformatf("cyc%0d dut%0d sram", cyc, d), 128'(pins_v[d]), 128'(exp_p));
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 256; i++) ref_mem[d][i] = init_word(i);

    // Stimulus table: {core req,we,be,addr,wdata, fab req,we,be,addr,wdata, rr gnt, prio gnt}
    vecs.push_back(mk(1, 1, 4'b0011, 32'h10, 32'hDEAD_BEEF, 0, 0, 4'hF, 32'h0, 32'h0, 2'b01, 2'b01));
    vecs.push_back(mk(0, 0, 4'hF, 32'h0,  32'h0, 0, 0, 4'hF, 32'h0,   32'h0, 2'b00, 2'b00));
    vecs.push_back(mk(1, 0, 4'hF, 32'h10, 32'h0, 0, 0, 4'hF, 32'h0,   32'h0, 2'b01, 2'b01));
    vecs.push_back(mk(0, 0, 4'hF, 32'h0,  32'h0, 0, 0, 4'hF, 32'h0,   32'h0, 2'b00, 2'b00));
    vecs.push_back(mk(0, 0, 4'hF, 32'h0,  32'h0, 1, 0, 4'hF, 32'h400, 32'h0, 2'b10, 2'b10));
    vecs.push_back(mk(1, 0, 4'hF, 32'h20, 32'h0, 0, 0, 4'hF, 32'h0,   32'h0, 2'b01, 2'b01));
    vecs.push_back(mk(0, 0, 4'hF, 32'h0,  32'h0, 1, 0, 4'hF, 32'h24,  32'h0, 2'b10, 2'b10));
    vecs.push_back(mk(0, 0, 4'hF, 32'h0,  32'h0, 0, 0, 4'hF, 32'h0,   32'h0, 2'b00, 2'b00));
    // Both requesting for 10 cycles: RR alternates, priority gives 4 core then 1 fabric.
    for (int i = 0; i < 10; i++)
      vecs.push_back(mk(1, 0, 4'hF, 32'h40 + 32'(4*i), 32'h0,
                        1, 0, 4'hF, 32'h80 + 32'(4*i), 32'h0,
                        (i % 2 == 0) ? 2'b01 : 2'b10,
                        (i == 4 || i == 9) ? 2'b10 : 2'b01));
    vecs.push_back(mk(0, 0, 4'hF, 32'h0, 32'h0, 0, 0, 4'hF, 32'h0, 32'h0, 2'b00, 2'b00));
    vecs.push_back(mk(0, 0, 4'hF, 32'h0, 32'h0, 1, 1, 4'b1100, 32'h8, 32'h1234_5678, 2'b10, 2'b10));
    vecs.push_back(mk(0, 0, 4'hF, 32'h0, 32'h0, 1, 0, 4'hF, 32'h8, 32'h0, 2'b10, 2'b10));
    vecs.push_back(mk(1, 1, 4'hF, 32'hFFFF_FFF0, 32'hA5A5_5A5A, 0, 0, 4'hF, 32'h0, 32'h0, 2'b01, 2'b01));
    vecs.push_back(mk(1, 0, 4'hF, 32'h30, 32'h0, 1, 0, 4'hF, 32'h34, 32'h0, 2'b10, 2'b01));
    vecs.push_back(mk(1, 0, 4'hF, 32'h30, 32'h0, 1, 0, 4'hF, 32'h34, 32'h0, 2'b01, 2'b01));
    vecs.push_back(mk(0, 0, 4'hF, 32'h0, 32'h0, 0, 0, 4'hF, 32'h0, 32'h0, 2'b00, 2'b00));

    // Power-on reset
    drive_idle();
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    #1 check_idle("por");
    @(negedge clk);
    resetn = 1'b1;

    for (int i = 0; i < vecs.size(); i++) step(vecs[i]);

    // Reset while a read response is due next cycle: it must be dropped.
    step(mk(1, 0, 4'hF, 32'h20, 32'h0, 0, 0, 4'hF, 32'h0, 32'h0, 2'b01, 2'b01));
    #1;
    resetn = 1'b0;
    sb_q.delete();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      creq = 1'b1; freq = 1'b1;
      #1 check_idle($sformatf("in_reset%0d", i));
    end
    @(negedge clk);
    drive_idle();
    resetn = 1'b1;
    #1 check_idle("post_reset");

    // First tie after reset goes to the core in both modes.
    step(mk(1, 0, 4'hF, 32'h40, 32'h0, 1, 0, 4'hF, 32'h44, 32'h0, 2'b01, 2'b01));
    step(mk(0, 0, 4'hF, 32'h0,  32'h0, 0, 0, 4'hF, 32'h0,  32'h0, 2'b00, 2'b00));

    check("scoreboard_drained", 128'(sb_q.size()), 128'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
